// File: rtl/logic_reduce_pkg.sv
// Shared definitions for the logic reduction unit.
//   - operator encodings carried on the 2-bit `op` input
//   - packet state encoding
//   - beat counter width and saturating increment helper
package logic_reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam int BEATS_W = 8;
  localparam logic [BEATS_W-1:0] BEATS_ONE = 8'd1;
  localparam logic [BEATS_W-1:0] BEATS_MAX = 8'd255;

  // Beat counter increment that sticks at the top value instead of wrapping.
  function automatic logic [BEATS_W-1:0] sat_inc(input logic [BEATS_W-1:0] count);
    logic [BEATS_W-1:0] next_count;
    if (count == BEATS_MAX) begin
      next_count = count;
    end else begin
      next_count = count + BEATS_ONE;
    end
    return next_count;
  endfunction

endpackage

// File: rtl/logic_reduce_unit_bitwise_fold.sv
// Purely combinational per-beat fold of NUM_IN packed words.
// Ports:
//   data  in  NUM_IN*WIDTH  word i at [i*WIDTH +: WIDTH]
//   op    in  2             operator; NOR folds as OR (inversion is the caller's job)
//   fold  out WIDTH         bitwise fold of all words
module bitwise_fold
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [1:0]              op,
  output logic [WIDTH-1:0]        fold
);

  // Fold words left to right; NOR shares the OR path so that multi-beat
  // accumulation can stay un-inverted until the final output write.
  always_comb begin
    fold = data[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      case (op)
        OP_AND:  fold = fold & data[i*WIDTH +: WIDTH];
        OP_XOR:  fold = fold ^ data[i*WIDTH +: WIDTH];
        OP_OR,
        OP_NOR:  fold = fold | data[i*WIDTH +: WIDTH];
        default: fold = fold | data[i*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Registered, parametrised bitwise reduction (OR/AND/XOR/NOR) of NUM_IN
// words per beat, optionally accumulated across a multi-beat packet, with
// one result per packet behind a valid/ready handshake.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input beat handshake
//   in_data              NUM_IN packed words of WIDTH bits
//   op, acc              operator and multi-beat flag, taken on a packet's first beat
//   in_last              final beat of an accumulating packet
//   out_valid/out_ready  result handshake
//   out_data, out_any    packet result and its OR-reduction
//   out_beats            beats in the packet, saturating at 255
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              op,
  input  logic                    acc,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic [BEATS_W-1:0]      out_beats
);

  state_e               state_r;
  logic [WIDTH-1:0]     acc_r;
  logic [1:0]           op_r;
  logic [BEATS_W-1:0]   count_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_data_r;
  logic                 out_any_r;
  logic [BEATS_W-1:0]   out_beats_r;

  logic                 accept_s;
  logic [1:0]           fold_op_s;
  logic [WIDTH-1:0]     fold_s;
  logic [WIDTH-1:0]     merged_s;
  logic [WIDTH-1:0]     result_s;
  logic [BEATS_W-1:0]   beats_s;
  logic                 write_s;
  logic                 start_s;

  // Two-operand form of the operator, used to merge a beat into the accumulator.
  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       o);
    logic [WIDTH-1:0] r;
    case (o)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_OR,
      OP_NOR:  r = a | b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  // Uniform ready rule: only out_ready reaches in_ready combinationally.
  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_any   = out_any_r;
  assign out_beats = out_beats_r;

  // Operator selection for the per-beat fold: a packet in flight keeps the
  // operator it started with, regardless of what is presented now.
  always_comb begin
    fold_op_s = op;
    if (state_r == ST_ACCUM) begin
      fold_op_s = op_r;
    end else begin
      fold_op_s = op;
    end
  end

  bitwise_fold #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_fold (
    .data (in_data),
    .op   (fold_op_s),
    .fold (fold_s)
  );

  // Next packet value, beat count, and whether this cycle writes a result.
  always_comb begin
    merged_s = fold_s;
    beats_s  = BEATS_ONE;
    write_s  = 1'b0;
    start_s  = 1'b0;
    result_s = fold_s;
    if (state_r == ST_ACCUM) begin
      merged_s = combine(acc_r, fold_s, op_r);
      beats_s  = sat_inc(count_r);
      write_s  = accept_s && in_last;
    end else begin
      merged_s = fold_s;
      beats_s  = BEATS_ONE;
      write_s  = accept_s && (!acc || in_last);
      start_s  = accept_s && acc && !in_last;
    end
    // NOR is carried as OR through accumulation; invert only here.
    if (fold_op_s == OP_NOR) begin
      result_s = ~merged_s;
    end else begin
      result_s = merged_s;
    end
  end

  // Packet FSM together with the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      op_r        <= 2'b00;
      count_r     <= {BEATS_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_any_r   <= 1'b0;
      out_beats_r <= {BEATS_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            acc_r   <= fold_s;
            op_r    <= op;
            count_r <= BEATS_ONE;
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r   <= merged_s;
            count_r <= beats_s;
            if (in_last) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // A new write wins over release so back-to-back results leave no bubble.
      if (write_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= result_s;
        out_any_r   <= |result_s;
        out_beats_r <= beats_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit (WIDTH=8, NUM_IN=2): a vector
// table for the directed scenarios, hand-written corner sequences, and
// randomized traffic checked against a packet-level reference model.
module tb_logic_reduce_unit;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [1:0]              op;
  logic                    acc;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_any;
  logic [7:0]              out_beats;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words of the open packet, and the expected held result.
  logic [7:0] m_words[$];
  int         m_nbeats;
  logic       m_inpkt;
  logic [1:0] m_op;
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_beats;

  logic_reduce_unit #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .acc       (acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
    .out_beats (out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [7:0] w0, input logic [7:0] w1);
    return {w1, w0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet result from the collected words, straight from the operator definition.
  task automatic model_finish();
    logic [7:0] r;
    case (m_op)
      2'b01: begin r = 8'hFF; foreach (m_words[i]) r = r & m_words[i]; end
      2'b10: begin r = 8'h00; foreach (m_words[i]) r = r ^ m_words[i]; end
      2'b11: begin r = 8'h00; foreach (m_words[i]) r = r | m_words[i]; r = ~r; end
      default: begin r = 8'h00; foreach (m_words[i]) r = r | m_words[i]; end
    endcase
    m_valid = 1'b1;
    m_data  = r;
    m_beats = (m_nbeats > 255) ? 8'd255 : 8'(m_nbeats);
    m_inpkt = 1'b0;
    m_words.delete();
    m_nbeats = 0;
  endtask

  task automatic model_reset();
    m_words.delete();
    m_nbeats = 0;
    m_inpkt  = 1'b0;
    m_op     = 2'b00;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_beats  = 8'h00;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] o,
                      input logic a, input logic l, input logic r);
    logic accept;
    in_valid  = v;
    in_data   = d;
    op        = o;
    acc       = a;
    in_last   = l;
    out_ready = r;
    #1;
    chk("in_ready", in_ready, !m_valid || r);
    accept = v && (!m_valid || r);
    @(posedge clk);
    if (m_valid && r) m_valid = 1'b0;
    if (accept) begin
      if (!m_inpkt) m_op = o;
      m_words.push_back(d[7:0]);
      m_words.push_back(d[15:8]);
      m_nbeats++;
      if (!m_inpkt && !(a && !l)) model_finish();
      else if (m_inpkt && l) model_finish();
      else m_inpkt = 1'b1;
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_beats", out_beats, m_beats);
      chk("out_any", out_any, |m_data);
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; out_ready held low so
  // in_ready=1 can only come from the cleared out_valid.
  task automatic reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_beats", out_beats, 8'h00);
    chk("rst_out_any", out_any, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  o;
    logic        a;
    logic        l;
    logic        r;
    logic        ev;
    logic [7:0]  ed;
    logic [7:0]  eb;
    logic        ea;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // OR sweep
    tbl[0] = '{1'b1, pk(8'h00, 8'h00), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'd1, 1'b0};
    tbl[1] = '{1'b1, pk(8'h00, 8'hFF), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'd1, 1'b1};
    tbl[2] = '{1'b1, pk(8'h0F, 8'hF0), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'd1, 1'b1};
    tbl[3] = '{1'b1, pk(8'hAA, 8'hAA), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'd1, 1'b1};
    // XOR accumulate
    tbl[4] = '{1'b1, pk(8'h01, 8'h02), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    tbl[5] = '{1'b1, pk(8'h04, 8'h00), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    tbl[6] = '{1'b1, pk(8'hFF, 8'h00), 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF8, 8'd3, 1'b1};
    // NOR with operator change ignored on the second beat
    tbl[7] = '{1'b1, pk(8'h00, 8'h01), 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    tbl[8] = '{1'b1, pk(8'h10, 8'h00), 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 8'd2, 1'b1};

    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    op        = 2'b00;
    acc       = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_data", out_data, 8'h00);
    chk("init_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].a, tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_beats", i), out_beats, tbl[i].eb);
        chk($sformatf("tbl%0d_any", i), out_any, tbl[i].ea);
      end
    end

    // Backpressure: result held stable, offered beats refused, then replaced with no bubble.
    step(1'b1, pk(8'h55, 8'h00), 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_data", out_data, 8'h55);
    end
    step(1'b1, pk(8'hF0, 8'h3C), 2'b01, 1'b0, 1'b0, 1'b1);
    chk("bp_new_valid", out_valid, 1'b1);
    chk("bp_new_data", out_data, 8'h30);

    // Reset with a result pending.
    reset_pulse();

    // Reset mid-packet discards the partial accumulation.
    step(1'b1, pk(8'hFF, 8'hFF), 2'b00, 1'b1, 1'b0, 1'b1);
    step(1'b1, pk(8'h0F, 8'h01), 2'b00, 1'b1, 1'b0, 1'b1);
    reset_pulse();
    step(1'b1, pk(8'hF0, 8'h3C), 2'b01, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_data", out_data, 8'h30);
    chk("mid_rst_beats", out_beats, 8'd1);

    // Saturation: 260-beat XOR packet, count pinned at 255, data exact.
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 16'($urandom), 2'b10, 1'b1, (i == 259) ? 1'b1 : 1'b0, 1'b1);
    end
    chk("sat_valid", out_valid, 1'b1);
    chk("sat_beats", out_beats, 8'd255);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_reduce_unit.md
# logic_reduce_unit

Parametrised, registered successor to the two-input OR gate. It folds `NUM_IN` words of `WIDTH` bits with a selectable bitwise operator (OR, AND, XOR, NOR). It can also accumulate that fold across a multi-beat packet and presents one registered result per packet behind a valid/ready handshake. It sits between flag/status producers and downstream consumers, for example interrupt aggregation and parity/mask reduction.

## Interface
- `WIDTH`, 8: bits per input word and per result; ≥1.
- `NUM_IN`, 2: number of input words folded per beat; ≥2.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: beat offered.
- `in_ready` output 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `in_data` input `NUM_IN*WIDTH`: word i at bits `[i*WIDTH +: WIDTH]`.
- `op` input 2: 00 OR, 01 AND, 10 XOR, 11 NOR; sampled on the first beat of a packet only.
- `acc` input 1: sampled on the first beat; 1 = multi-beat packet ending at `in_last`, 0 = single-beat packet.
- `in_last` input 1: final beat of an accumulating packet; ignored when the packet is single-beat.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output `WIDTH`: packet result.
- `out_any` output 1: OR-reduction of `out_data`.
- `out_beats` output 8: beats in the packet, saturating at 255.

## Operation
- **Per-beat fold:** `f` = bitwise fold of all `NUM_IN` words. NOR folds as OR, and inversion is applied only at the output.
- **Packet result:** the operator applied over all `NUM_IN × beats` words, i.e. OR, AND, XOR, or ~(OR of everything).
- **States:**
  - **IDLE.** An accepted beat with `acc=0`, or with `acc=1 && in_last=1`, writes the output register; the state stays IDLE. An accepted beat with `acc=1 && in_last=0` loads accumulator ← `f`, latches `op`, sets count=1 and moves to ACCUM.
  - **ACCUM.** An accepted beat combines accumulator ← accumulator op `f` using the latched `op`, and count increments (saturating). If `in_last=1`, the output register is written and the state returns to IDLE.
  - `op` and `acc` presented on non-first beats are ignored.
- **Output write:** loads `out_data` with the final result (inverted if NOR), loads `out_beats`, and sets `out_valid`.
- **Output release:** `out_valid` clears on `out_valid && out_ready` unless a new write happens in the same cycle, in which case the new result replaces the old and `out_valid` stays 1.
- **Input ready:** `in_ready = !out_valid || out_ready` in every state. The rule is uniform so that `in_ready` has no combinational dependence on `in_valid`.
- **Reset values:** `out_valid` 0, `out_data` 0, `out_any` 0, `out_beats` 0, state IDLE, accumulator 0. `in_ready` is 1 both while and after reset is asserted.
- **Reset mid-packet:** the partial accumulation is discarded with no output, and `out_valid` drops immediately (asynchronously).
- **Saturation:** `out_beats` stays at 255 for packets of 255 or more beats; the data fold remains exact.

## Timing
- **Latency:** a final beat accepted at edge k gives `out_valid=1` and valid data from edge k onward, visible in cycle k+1.
- **Throughput:** one single-beat packet per cycle when `out_ready=1` continuously.
- **Backpressure:** `out_data`, `out_beats` and `out_any` are stable while `out_valid && !out_ready`.
- **Combinational paths:** `out_ready` → `in_ready` only.
- **Registered outputs:** all other outputs come directly from registers; `out_any` is a fold of the `out_data` register.

## Structure
- Package `logic_reduce_pkg` holds:
  - the `op` encodings (`OP_OR`, `OP_AND`, `OP_XOR`, `OP_NOR`);
  - the state encoding (`ST_IDLE`, `ST_ACCUM`);
  - the `BEATS_W=8` constant.
- Sub-module `bitwise_fold`, parametrised by `WIDTH` and `NUM_IN`, is purely combinational: the packed words plus `op` go in, and the per-beat fold `f` comes out. It is instantiated once.

## Test plan
All scenarios use `WIDTH=8`, `NUM_IN=2`.
- **Reset:** assert `rst_n=0` mid-run → `out_valid=0`, `out_data=0x00`, `out_beats=0`, `in_ready=1`.
- **OR sweep:** single beats with `op=00`, `(0x00,0x00)`, `(0x00,0xFF)`, `(0x0F,0xF0)` and `(0xAA,0xAA)` on consecutive cycles with `out_ready=1` → results `0x00`, `0xFF`, `0xFF`, `0xAA`, each one cycle after acceptance, `out_beats=1`, and `out_any` = 0,1,1,1.
- **XOR accumulate:** `acc=1`, `op=10`, beats `(0x01,0x02)`, `(0x04,0x00)`, `(0xFF,0x00, last)` → a single result `0xF8` with `out_beats=3`, and no `out_valid` before the last beat.
- **NOR with ignored op change:** first beat `op=11`, `(0x00,0x01)`; second beat `op=00`, `(0x10,0x00)`, last → `out_data=0xEE`, `out_any=1`.
- **Backpressure:** hold `out_ready=0` with a result pending → `in_ready=0` and the result stays stable for 5 cycles. Then raise `out_ready` while offering `(0xF0,0x3C)` with `op=01` → `0x30` replaces the old result with no bubble.
- **Reset mid-packet:** pulse `rst_n` low after 2 beats of an accumulating packet → no output for that packet. A following single beat AND of `(0xF0,0x3C)` → `0x30`, `out_beats=1`.
